// File: rtl/pong_pkg.sv
// Shared types and constants for the pong game controller and datapath.
package pong_pkg;

  localparam int SCORE_W  = 8;
  localparam int SPEED_W  = 4;
  localparam int CNT_W    = 8;
  localparam int CENTER_X = 320;
  localparam int CENTER_Y = 240;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SERVE = 3'd1,
    PLAY  = 3'd2,
    POINT = 3'd3,
    OVER  = 3'd4
  } state_t;

  // Scores stick at the top of their range instead of wrapping.
  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
    return (v == {SCORE_W{1'b1}}) ? v : v + SCORE_W'(1);
  endfunction

endpackage

// File: rtl/pong_game_ctrl_if.sv
// Strobe/status bundle between the playfield logic (master) and the game controller (slave).
interface pong_game_ctrl_if;
  import pong_pkg::*;

  logic               vsync;
  logic               start;
  logic               p1_point;
  logic               p2_point;
  logic               paddle_hit;
  logic               ball_run;
  logic               ball_center;
  logic               serve_left;
  logic [SPEED_W-1:0] ball_speed;
  logic [SCORE_W-1:0] score1;
  logic [SCORE_W-1:0] score2;
  logic               game_over;
  logic               winner;
  logic [2:0]         state;

  modport master (
    output vsync, start, p1_point, p2_point, paddle_hit,
    input  ball_run, ball_center, serve_left, ball_speed,
           score1, score2, game_over, winner, state
  );

  modport slave (
    input  vsync, start, p1_point, p2_point, paddle_hit,
    output ball_run, ball_center, serve_left, ball_speed,
           score1, score2, game_over, winner, state
  );

endinterface

// File: rtl/pong_frame_tick.sv
// vsync two-flop synchroniser and rising-edge detector; frame_tick is one clk wide,
// registered, and appears 3 clk after the vsync rise.
module pong_frame_tick (
  input  logic clk,
  input  logic reset,
  input  logic vsync,
  output logic frame_tick
);

  logic [1:0] sync_reg;
  logic       prev_reg;
  logic       tick_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_reg <= 2'b00;
      prev_reg <= 1'b0;
      tick_reg <= 1'b0;
    end else begin
      sync_reg <= {sync_reg[0], vsync};
      prev_reg <= sync_reg[1];
      tick_reg <= sync_reg[1] & ~prev_reg;
    end
  end

  assign frame_tick = tick_reg;

endmodule

// File: rtl/pong_game_ctrl.sv
// Pong match sequencer: match flow, scores, serve direction and ball speed.
// Define PONG_RALLY_SPEEDUP_EN to speed the ball up as a rally lengthens.
module pong_game_ctrl
  import pong_pkg::*;
#(
  parameter int WIN_SCORE       = 11,
  parameter int SERVE_FRAMES    = 60,
  parameter int POINT_FRAMES    = 90,
  parameter int BALL_SPEED      = 8,
  parameter int SPEED_STEP_HITS = 4,
  parameter int MAX_SPEED       = 12
) (
  input  logic             clk,
  input  logic             reset,
  pong_game_ctrl_if.slave  bus
);

  localparam logic [CNT_W-1:0]   SERVE_LAST = CNT_W'(SERVE_FRAMES - 1);
  localparam logic [CNT_W-1:0]   POINT_LAST = CNT_W'(POINT_FRAMES - 1);
  localparam logic [SCORE_W-1:0] WIN_VAL    = SCORE_W'(WIN_SCORE);
  localparam logic [SPEED_W-1:0] BASE_SPEED = SPEED_W'(BALL_SPEED);

  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   frame_cnt_reg;
  logic [SCORE_W-1:0] score1_reg, score2_reg;
  logic               serve_left_reg, winner_reg;
  logic               ball_run_reg, ball_center_reg, game_over_reg;
  logic               ball_run_next, ball_center_next, game_over_next;
  logic               frame_tick;
  logic               serve_done, point_done, any_point, win_reached;

  pong_frame_tick u_frame_tick (
    .clk        (clk),
    .reset      (reset),
    .vsync      (bus.vsync),
    .frame_tick (frame_tick)
  );

  assign serve_done  = frame_tick && (frame_cnt_reg == SERVE_LAST);
  assign point_done  = frame_tick && (frame_cnt_reg == POINT_LAST);
  assign any_point   = bus.p1_point | bus.p2_point;
  assign win_reached = (score1_reg == WIN_VAL) || (score2_reg == WIN_VAL);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (bus.start) state_next = SERVE;
      SERVE:   if (serve_done) state_next = PLAY;
      PLAY:    if (any_point) state_next = POINT;
      POINT:   if (point_done) state_next = win_reached ? OVER : SERVE;
      OVER:    if (bus.start) state_next = SERVE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs follow the registered state, so they lag a transition by one clk.
  always_comb begin
    ball_run_next    = (state_reg == PLAY);
    ball_center_next = (state_reg != PLAY);
    game_over_next   = (state_reg == OVER);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ball_run_reg    <= 1'b0;
      ball_center_reg <= 1'b1;
      game_over_reg   <= 1'b0;
    end else begin
      ball_run_reg    <= ball_run_next;
      ball_center_reg <= ball_center_next;
      game_over_reg   <= game_over_next;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_cnt_reg  <= '0;
      score1_reg     <= '0;
      score2_reg     <= '0;
      serve_left_reg <= 1'b0;
      winner_reg     <= 1'b0;
    end else begin
      case (state_reg)
        IDLE, OVER: begin
          if (bus.start) begin
            frame_cnt_reg  <= '0;
            score1_reg     <= '0;
            score2_reg     <= '0;
            serve_left_reg <= 1'b0;
          end
        end
        SERVE: begin
          if (frame_tick) frame_cnt_reg <= serve_done ? '0 : frame_cnt_reg + CNT_W'(1);
        end
        PLAY: begin
          // Serve goes toward whoever conceded; p1 wins a simultaneous strobe.
          if (bus.p1_point) begin
            score1_reg     <= sat_inc(score1_reg);
            serve_left_reg <= 1'b1;
            frame_cnt_reg  <= '0;
          end else if (bus.p2_point) begin
            score2_reg     <= sat_inc(score2_reg);
            serve_left_reg <= 1'b0;
            frame_cnt_reg  <= '0;
          end
        end
        POINT: begin
          if (frame_tick) frame_cnt_reg <= point_done ? '0 : frame_cnt_reg + CNT_W'(1);
          if (point_done && win_reached) winner_reg <= (score2_reg == WIN_VAL);
        end
        default: ;
      endcase
    end
  end

`ifdef PONG_RALLY_SPEEDUP_EN
  localparam logic [7:0]         HIT_LAST  = 8'(SPEED_STEP_HITS - 1);
  localparam logic [SPEED_W-1:0] TOP_SPEED = SPEED_W'(MAX_SPEED);

  logic [7:0]         hit_cnt_reg;
  logic [SPEED_W-1:0] speed_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hit_cnt_reg <= '0;
      speed_reg   <= BASE_SPEED;
    end else if (state_reg == PLAY) begin
      if (any_point) begin
        hit_cnt_reg <= '0;
        speed_reg   <= BASE_SPEED;
      end else if (bus.paddle_hit) begin
        if (hit_cnt_reg == HIT_LAST) begin
          hit_cnt_reg <= '0;
          if (speed_reg < TOP_SPEED) speed_reg <= speed_reg + SPEED_W'(1);
        end else begin
          hit_cnt_reg <= hit_cnt_reg + 8'd1;
        end
      end
    end
  end

  assign bus.ball_speed = speed_reg;
`else
  logic unused_speedup;
  assign unused_speedup = ^{bus.paddle_hit, 8'(SPEED_STEP_HITS), 8'(MAX_SPEED)};
  assign bus.ball_speed = BASE_SPEED;
`endif

  assign bus.state       = state_reg;
  assign bus.score1      = score1_reg;
  assign bus.score2      = score2_reg;
  assign bus.serve_left  = serve_left_reg;
  assign bus.winner      = winner_reg;
  assign bus.ball_run    = ball_run_reg;
  assign bus.ball_center = ball_center_reg;
  assign bus.game_over   = game_over_reg;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Self-checking bench for pong_game_ctrl: directed test-plan scenarios followed by
// random events, all checked against a rule-level match model.
module tb_pong_game_ctrl;
  import pong_pkg::*;

  localparam int WIN  = 11;
  localparam int SF   = 60;
  localparam int PF   = 90;
  localparam int BS   = 8;
  localparam int STEP = 4;
  localparam int MAXS = 12;
`ifdef PONG_RALLY_SPEEDUP_EN
  localparam bit SPEEDUP = 1'b1;
`else
  localparam bit SPEEDUP = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  pong_game_ctrl_if bus ();

  pong_game_ctrl #(
    .WIN_SCORE(WIN), .SERVE_FRAMES(SF), .POINT_FRAMES(PF),
    .BALL_SPEED(BS), .SPEED_STEP_HITS(STEP), .MAX_SPEED(MAXS)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Match model: phase (0 idle,1 serve,2 play,3 point,4 over), scores, frames seen in phase.
  int m_phase, m_s1, m_s2, m_frames, m_hits;
  bit m_serve_left, m_winner;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic int exp_speed();
    int s;
    if (!SPEEDUP) return BS;
    s = BS + m_hits / STEP;
    return (s > MAXS) ? MAXS : s;
  endfunction

  task automatic check_all(input string ctx);
    check_eq({ctx, " state"},       32'(bus.state),       32'(m_phase));
    check_eq({ctx, " score1"},      32'(bus.score1),      32'(m_s1));
    check_eq({ctx, " score2"},      32'(bus.score2),      32'(m_s2));
    check_eq({ctx, " serve_left"},  32'(bus.serve_left),  32'(m_serve_left));
    check_eq({ctx, " ball_run"},    32'(bus.ball_run),    32'(m_phase == 2));
    check_eq({ctx, " ball_center"}, 32'(bus.ball_center), 32'(m_phase != 2));
    check_eq({ctx, " game_over"},   32'(bus.game_over),   32'(m_phase == 4));
    check_eq({ctx, " ball_speed"},  32'(bus.ball_speed),  32'(exp_speed()));
    if (m_phase == 4) check_eq({ctx, " winner"}, 32'(bus.winner), 32'(m_winner));
    $display("[TB] %-10s phase=%0d s1=%0d s2=%0d serve_left=%0d speed=%0d",
             ctx, bus.state, bus.score1, bus.score2, bus.serve_left, bus.ball_speed);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_phase = 0; m_s1 = 0; m_s2 = 0; m_frames = 0; m_hits = 0;
    m_serve_left = 0; m_winner = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    step();
    model_reset();
    check_all("reset");
  endtask

  task automatic do_frames(input int n);
    for (int i = 0; i < n; i++) begin
      bus.vsync = 1'b1;
      step(); step();
      bus.vsync = 1'b0;
      repeat (6) step();
      if (m_phase == 1) begin
        m_frames++;
        if (m_frames == SF) begin m_phase = 2; m_frames = 0; end
      end else if (m_phase == 3) begin
        m_frames++;
        if (m_frames == PF) begin
          m_frames = 0;
          if (m_s1 == WIN || m_s2 == WIN) begin
            m_phase  = 4;
            m_winner = (m_s2 == WIN);
          end else begin
            m_phase = 1;
          end
        end
      end
    end
    check_all($sformatf("frames%0d", n));
  endtask

  task automatic do_start();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    step(); step();
    if (m_phase == 0 || m_phase == 4) begin
      m_phase = 1; m_s1 = 0; m_s2 = 0; m_frames = 0; m_serve_left = 0;
    end
    check_all("start");
  endtask

  task automatic do_strobe(input bit p1, input bit p2, input bit hit);
    bus.p1_point = p1; bus.p2_point = p2; bus.paddle_hit = hit;
    step();
    bus.p1_point = 1'b0; bus.p2_point = 1'b0; bus.paddle_hit = 1'b0;
    step(); step();
    if (m_phase == 2) begin
      if (p1) begin
        m_s1 = (m_s1 == 255) ? 255 : m_s1 + 1;
        m_serve_left = 1; m_phase = 3; m_frames = 0; m_hits = 0;
      end else if (p2) begin
        m_s2 = (m_s2 == 255) ? 255 : m_s2 + 1;
        m_serve_left = 0; m_phase = 3; m_frames = 0; m_hits = 0;
      end else if (hit) begin
        m_hits++;
      end
    end
    check_all(p1 ? (p2 ? "both" : "p1_point") : (p2 ? "p2_point" : "hit"));
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int guard;
    bus.vsync = 1'b0; bus.start = 1'b0;
    bus.p1_point = 1'b0; bus.p2_point = 1'b0; bus.paddle_hit = 1'b0;
    reset = 1'b1;
    model_reset();
    do_reset();

    // Serve, rally, a p2 point and its pause.
    do_start();
    do_frames(30);
    do_frames(30);
    do_strobe(0, 1, 0);
    do_frames(PF);
    do_frames(SF);

    // Simultaneous points from a fresh match.
    do_reset();
    do_start();
    do_frames(SF);
    do_strobe(1, 1, 0);
    check_eq("both s1=1", 32'(bus.score1), 32'd1);
    check_eq("both s2=0", 32'(bus.score2), 32'd0);
    do_frames(PF);
    do_frames(SF);

    // Rally speed-up and its reset on a point.
    repeat (8) do_strobe(0, 0, 1);
    check_eq("speed after 8 hits", 32'(bus.ball_speed), SPEEDUP ? 32'd10 : 32'd8);
    repeat (12) do_strobe(0, 0, 1);
    check_eq("speed after 20 hits", 32'(bus.ball_speed), SPEEDUP ? 32'd12 : 32'd8);
    do_strobe(1, 0, 0);
    check_eq("speed after point", 32'(bus.ball_speed), 32'd8);

    // Full match to WIN p1 points.
    do_reset();
    do_start();
    do_frames(SF);
    guard = 0;
    while (m_phase != 4 && guard < 60) begin
      if (m_phase == 2)      do_strobe(1, 0, 0);
      else if (m_phase == 3) do_frames(PF);
      else                   do_frames(SF);
      guard++;
    end
    check_eq("over state", 32'(bus.state), 32'd4);
    check_eq("over game_over", 32'(bus.game_over), 32'd1);
    check_eq("over winner", 32'(bus.winner), 32'd0);
    check_eq("over score1", 32'(bus.score1), 32'(WIN));
    repeat (3) do_strobe(0, 1, 0);
    check_eq("over score2 held", 32'(bus.score2), 32'd0);
    do_start();
    check_eq("restart state", 32'(bus.state), 32'd1);

    // Asynchronous reset mid-rally, between clock edges.
    do_frames(SF);
    do_strobe(1, 0, 0);
    do_frames(PF);
    do_frames(SF);
    do_frames(10);
    bus.vsync = 1'b1;
    step();
    #3 reset = 1'b1;
    #1;
    check_eq("async state", 32'(bus.state), 32'd0);
    check_eq("async score1", 32'(bus.score1), 32'd0);
    check_eq("async ball_center", 32'(bus.ball_center), 32'd1);
    check_eq("async ball_run", 32'(bus.ball_run), 32'd0);
    bus.vsync = 1'b0;
    step();
    reset = 1'b0;
    step();
    model_reset();
    check_all("post_async");

    // Random event mix.
    for (int k = 0; k < 150; k++) begin
      int r;
      r = $urandom_range(0, 9);
      case (r)
        0, 1, 2, 3: do_frames($urandom_range(1, 100));
        4:          do_start();
        5:          do_strobe(1, 0, 0);
        6:          do_strobe(0, 1, 0);
        7:          do_strobe(1, 1, 0);
        8:          do_strobe(0, 0, 1);
        default:    if ($urandom_range(0, 9) == 0) do_reset(); else do_strobe(0, 0, 1);
      endcase
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
